control_decode_pipe: RTL and testbench
======================================

# control_decode_pipe

Parametrised RV32I control stage that decodes a fetched instruction into a complete control bundle and holds it in a DEPTH-entry buffer. It sits between fetch and execute. It covers every RV32I opcode, not only OP/OP-IMM. It generates the sign-extended immediate and flags illegal encodings, and it gives execute a valid/ready handshake plus a synchronous flush for branch redirects.

## Interface
- DEPTH, 2: buffered control entries, 1..4; 2 gives full throughput with registered ready
- ILL_CNT_W, 16: width of the saturating illegal-instruction counter
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  instruction/PC pair offered
- in_ready  out  1  slot available (registered, !full)
- instruction  in  32  raw instruction word
- pc  in  32  instruction address
- flush  in  1  discard all buffered entries and the current offer
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- ctrl  out  ctrl_t  head bundle: regfile_wr_en, mem_read, mem_write, mem_to_reg, branch, jump, rs1_select (0 = rs1, 1 = PC), rs2_select (0 = rs2, 1 = imm), alu_select[2:0], alu_operation[7:0], mem_funct3[2:0], imm[31:0], rd, rs1, rs2, pc, illegal
- illegal_count  out  ILL_CNT_W  illegal instructions accepted since reset, saturating

## Operation
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush.
- Buffer is a circular queue with wr_ptr, rd_ptr and count. Pointers wrap at DEPTH-1 → 0.
- Decode per opcode:
  - OP: rs2_select=0, ALU op from funct3/funct7[5].
  - OP-IMM: rs2_select=1, I-imm. SRLI/SRAI are distinguished by instr[30].
  - LOAD: mem_read, mem_to_reg, ADD, I-imm.
  - STORE: mem_write, ADD, S-imm, regfile_wr_en=0.
  - BRANCH: branch, alu_select=COMPARE, alu_operation=funct3, B-imm.
  - JAL: jump, rs1_select=1, J-imm.
  - JALR: jump, I-imm.
  - LUI: rs1 forced to x0, U-imm.
  - AUIPC: rs1_select=1, U-imm.
  - FENCE: NOP.
- Illegal cases:
  - unknown opcode;
  - OP with funct7 other than 0x00/0x20, or 0x20 with funct3 other than ADD/SRL;
  - SLLI/SRLI/SRAI with bad funct7;
  - unused funct3 for LOAD/STORE/BRANCH/JALR.
- An illegal entry carries illegal=1, all write and memory enables 0, alu_select=NOP, alu_operation=NOP.
- rd=x0 forces regfile_wr_en=0.
- illegal_count increments on a push of an illegal entry and stops at all-ones.
- Flush resets both pointers and count to 0 and drops the same-cycle offer. illegal_count is unaffected.

## Timing
- Reset values:
  - out_valid=0, in_ready=1, count=0, pointers=0, illegal_count=0.
  - ctrl contents are don't-care while out_valid=0 but reset to all-zero.
- Latency: an instruction pushed at edge N appears with out_valid=1 after edge N (1 cycle).
- in_ready depends only on registered count.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - in_ready rises the cycle after the pop.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Push into an empty buffer makes the entry visible next cycle; there is no combinational bypass.
- out_valid and ctrl must hold stable while out_valid && !out_ready, unless flush or rst is asserted.
- Flush has priority over push and pop. rst has priority over everything.
  - Reset mid-stream discards all entries.

## Structure
- isa_pkg holds the following:
  - opcode, funct3 and funct7 constants;
  - ALU_SELECT_{NOP=0, ARITHMETIC=1, COMPARE=2};
  - ALU_OPERATIONS_{NOP=0x00, ADD=0x01, SUB=0x02, AND=0x03, OR=0x04, XOR=0x05, SLL=0x06, SRL=0x07, SRA=0x08, SLT=0x09, SLTU=0x0A};
  - the ctrl_t packed struct.
- Sub-module control_decode is purely combinational: instruction + pc → ctrl_t, including the immediate generator.
- The top level holds the queue and the counter.

## Test plan
- Push 0x002081B3 (add x3,x1,x2) with out_ready=1 → next cycle ctrl: alu_operation=0x01, rd=3, rs1=1, rs2=2, regfile_wr_en=1, rs2_select=0, illegal=0.
- Push 0x00812283 (lw x5,8(x2)) then 0x00208463 (beq x1,x2,+8) → lw entry: mem_read=1, mem_to_reg=1, imm=8, mem_funct3=2; beq entry: branch=1, regfile_wr_en=0, imm=8, alu_select=2.
- Push 0x00000000 twice, then 0xFFF00093 (addi x1,x0,-1) → two entries with illegal=1 and all enables 0; illegal_count=2; addi entry has imm=0xFFFFFFFF, rs2_select=1, illegal=0.
- DEPTH=2, out_ready=0, push 3 back-to-back → in_ready=0 after 2 pushes; third held until out_ready=1; order of the 3 entries preserved.
- Buffer holds 2 entries with in_valid=1, assert flush for 1 cycle → next cycle out_valid=0, count=0, the offered instruction is not enqueued, illegal_count unchanged.
- Assert rst while the buffer is full → next cycle out_valid=0, in_ready=1, illegal_count=0.

Source files
------------

// File: rtl/isa_pkg.sv
// RV32I encoding constants, ALU operation codes and the decoded control bundle
// shared by the decoder and the control buffer.
package isa_pkg;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [2:0] ALU_SELECT_NOP        = 3'd0;
  localparam logic [2:0] ALU_SELECT_ARITHMETIC = 3'd1;
  localparam logic [2:0] ALU_SELECT_COMPARE    = 3'd2;

  localparam logic [7:0] ALU_OPERATIONS_NOP  = 8'h00;
  localparam logic [7:0] ALU_OPERATIONS_ADD  = 8'h01;
  localparam logic [7:0] ALU_OPERATIONS_SUB  = 8'h02;
  localparam logic [7:0] ALU_OPERATIONS_AND  = 8'h03;
  localparam logic [7:0] ALU_OPERATIONS_OR   = 8'h04;
  localparam logic [7:0] ALU_OPERATIONS_XOR  = 8'h05;
  localparam logic [7:0] ALU_OPERATIONS_SLL  = 8'h06;
  localparam logic [7:0] ALU_OPERATIONS_SRL  = 8'h07;
  localparam logic [7:0] ALU_OPERATIONS_SRA  = 8'h08;
  localparam logic [7:0] ALU_OPERATIONS_SLT  = 8'h09;
  localparam logic [7:0] ALU_OPERATIONS_SLTU = 8'h0A;

  typedef struct packed {
    logic        regfile_wr_en;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        rs1_select;
    logic        rs2_select;
    logic [2:0]  alu_select;
    logic [7:0]  alu_operation;
    logic [2:0]  mem_funct3;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic        illegal;
  } ctrl_t;

  // alt selects SUB for funct3=ADD and SRA for funct3=SRL
  function automatic logic [7:0] alu_op_of(input logic [2:0] f3, input logic alt);
    logic [7:0] op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_OPERATIONS_SUB : ALU_OPERATIONS_ADD;
      F3_SLL:     op = ALU_OPERATIONS_SLL;
      F3_SLT:     op = ALU_OPERATIONS_SLT;
      F3_SLTU:    op = ALU_OPERATIONS_SLTU;
      F3_XOR:     op = ALU_OPERATIONS_XOR;
      F3_SRL_SRA: op = alt ? ALU_OPERATIONS_SRA : ALU_OPERATIONS_SRL;
      F3_OR:      op = ALU_OPERATIONS_OR;
      F3_AND:     op = ALU_OPERATIONS_AND;
      default:    op = ALU_OPERATIONS_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational RV32I decoder: instruction + pc to a full control bundle,
// including immediate generation and illegal-encoding detection.
module control_decode
  import isa_pkg::*;
(
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  output ctrl_t       ctrl_c
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bad;
  ctrl_t       d;

  always_comb begin
    opcode = instruction[6:0];
    f3     = instruction[14:12];
    f7     = instruction[31:25];
    imm_i  = {{20{instruction[31]}}, instruction[31:20]};
    imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
              instruction[30:25], instruction[11:8], 1'b0};
    imm_u  = {instruction[31:12], 12'b0};
    imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
              instruction[20], instruction[30:21], 1'b0};
    bad    = 1'b0;
    d      = '0;
    d.pc   = pc;
    d.rd   = instruction[11:7];
    d.rs1  = instruction[19:15];
    d.rs2  = instruction[24:20];

    case (opcode)
      OPCODE_OP: begin
        d.regfile_wr_en = 1'b1;
        d.alu_select    = ALU_SELECT_ARITHMETIC;
        d.alu_operation = alu_op_of(f3, f7[5]);
        bad = !((f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))));
      end
      OPCODE_OP_IMM: begin
        d.regfile_wr_en = 1'b1;
        d.rs2_select    = 1'b1;
        d.imm           = imm_i;
        d.alu_select    = ALU_SELECT_ARITHMETIC;
        // upper immediate bits double as funct7 only for the shift forms
        d.alu_operation = alu_op_of(f3, (f3 == F3_SRL_SRA) && instruction[30]);
        if (f3 == F3_SLL)
          bad = (f7 != F7_BASE);
        else if (f3 == F3_SRL_SRA)
          bad = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      OPCODE_LOAD: begin
        d.regfile_wr_en = 1'b1;
        d.mem_read      = 1'b1;
        d.mem_to_reg    = 1'b1;
        d.rs2_select    = 1'b1;
        d.imm           = imm_i;
        d.alu_select    = ALU_SELECT_ARITHMETIC;
        d.alu_operation = ALU_OPERATIONS_ADD;
        d.mem_funct3    = f3;
        bad = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      end
      OPCODE_STORE: begin
        d.mem_write     = 1'b1;
        d.rs2_select    = 1'b1;
        d.imm           = imm_s;
        d.alu_select    = ALU_SELECT_ARITHMETIC;
        d.alu_operation = ALU_OPERATIONS_ADD;
        d.mem_funct3    = f3;
        bad = !(f3 inside {F3_SB, F3_SH, F3_SW});
      end
      OPCODE_BRANCH: begin
        d.branch        = 1'b1;
        d.imm           = imm_b;
        d.alu_select    = ALU_SELECT_COMPARE;
        d.alu_operation = 8'(f3);
        bad = !(f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
      end
      OPCODE_JAL: begin
        d.regfile_wr_en = 1'b1;
        d.jump          = 1'b1;
        d.rs1_select    = 1'b1;
        d.rs2_select    = 1'b1;
        d.imm           = imm_j;
        d.alu_select    = ALU_SELECT_ARITHMETIC;
        d.alu_operation = ALU_OPERATIONS_ADD;
      end
      OPCODE_JALR: begin
        d.regfile_wr_en = 1'b1;
        d.jump          = 1'b1;
        d.rs2_select    = 1'b1;
        d.imm           = imm_i;
        d.alu_select    = ALU_SELECT_ARITHMETIC;
        d.alu_operation = ALU_OPERATIONS_ADD;
        bad = (f3 != F3_JALR);
      end
      OPCODE_LUI: begin
        d.regfile_wr_en = 1'b1;
        d.rs1           = 5'd0;
        d.rs2_select    = 1'b1;
        d.imm           = imm_u;
        d.alu_select    = ALU_SELECT_ARITHMETIC;
        d.alu_operation = ALU_OPERATIONS_ADD;
      end
      OPCODE_AUIPC: begin
        d.regfile_wr_en = 1'b1;
        d.rs1_select    = 1'b1;
        d.rs2_select    = 1'b1;
        d.imm           = imm_u;
        d.alu_select    = ALU_SELECT_ARITHMETIC;
        d.alu_operation = ALU_OPERATIONS_ADD;
      end
      OPCODE_MISC_MEM: ;
      default: bad = 1'b1;
    endcase

    // illegal entries keep only their address and register fields
    if (bad) begin
      d         = '0;
      d.illegal = 1'b1;
      d.pc      = pc;
      d.rd      = instruction[11:7];
      d.rs1     = instruction[19:15];
      d.rs2     = instruction[24:20];
    end
    if (d.rd == 5'd0)
      d.regfile_wr_en = 1'b0;
    ctrl_c = d;
  end

endmodule

// File: rtl/control_decode_pipe.sv
// Fetch-to-execute control stage: decodes each accepted instruction and holds
// the bundles in a DEPTH-entry circular queue with valid/ready and flush.
module control_decode_pipe
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instruction,
  input  logic [31:0]          pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output ctrl_t                ctrl,
  output logic [ILL_CNT_W-1:0] illegal_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  ctrl_t             mem [DEPTH];
  ctrl_t             dec_c;
  ctrl_t             head_nxt_c;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_nxt_c, rd_nxt_c;
  logic [CNT_W-1:0]  count, cnt_nxt_c;
  logic              push_c, pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  control_decode u_decode (
    .instruction (instruction),
    .pc          (pc),
    .ctrl_c      (dec_c)
  );

  // Next queue state; flush wins over push and pop.
  always_comb begin
    push_c    = in_valid && in_ready && !flush;
    pop_c     = out_valid && out_ready && !flush;
    wr_nxt_c  = wr_ptr;
    rd_nxt_c  = rd_ptr;
    cnt_nxt_c = count;
    if (flush) begin
      wr_nxt_c  = '0;
      rd_nxt_c  = '0;
      cnt_nxt_c = '0;
    end else begin
      if (push_c)
        wr_nxt_c = ptr_inc(wr_ptr);
      if (pop_c)
        rd_nxt_c = ptr_inc(rd_ptr);
      if (push_c && !pop_c)
        cnt_nxt_c = count + CNT_W'(1);
      else if (!push_c && pop_c)
        cnt_nxt_c = count - CNT_W'(1);
    end
    // new head is the entry being written this cycle when the slots coincide
    head_nxt_c = (push_c && (rd_nxt_c == wr_ptr)) ? dec_c : mem[rd_nxt_c];
  end

  always_ff @(posedge clk) begin
    if (push_c)
      mem[wr_ptr] <= dec_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      ctrl          <= '0;
      illegal_count <= '0;
    end else begin
      wr_ptr    <= wr_nxt_c;
      rd_ptr    <= rd_nxt_c;
      count     <= cnt_nxt_c;
      in_ready  <= (cnt_nxt_c < CNT_W'(DEPTH));
      out_valid <= (cnt_nxt_c != '0);
      ctrl      <= head_nxt_c;
      if (push_c && dec_c.illegal && !(&illegal_count))
        illegal_count <= illegal_count + ILL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_decode_pipe.sv
// Self-checking bench for control_decode_pipe: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_control_decode_pipe;
  import isa_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  ctrl_t       ctrl;
  logic [15:0] illegal_count;

  int total = 0;
  int bad   = 0;

  control_decode_pipe #(.DEPTH(DEPTH), .ILL_CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instruction   (instruction),
    .pc            (pc),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ctrl          (ctrl),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [7:0] tbl [8] = '{8'h01, 8'h06, 8'h09, 8'h0A, 8'h05, 8'h07, 8'h04, 8'h03};
    if (alt && f3 == 3'd0) return 8'h02;
    if (alt && f3 == 3'd5) return 8'h08;
    return tbl[f3];
  endfunction

  // Reference decode written from the ISA field layout.
  function automatic ctrl_t ref_decode(input logic [31:0] w, input logic [31:0] a);
    ctrl_t c;
    logic signed [31:0] sw;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    sw = w;
    f3 = w[14:12];
    f7 = w[31:25];
    ok = 1'b1;
    c = '0;
    c.pc = a; c.rd = w[11:7]; c.rs1 = w[19:15]; c.rs2 = w[24:20];
    case (w[6:0])
      7'h33: begin
        c.regfile_wr_en = 1; c.alu_select = 3'd1;
        c.alu_operation = arith_op(f3, f7 == 7'h20);
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        c.regfile_wr_en = 1; c.rs2_select = 1; c.alu_select = 3'd1;
        c.imm = 32'(sw >>> 20);
        c.alu_operation = arith_op(f3, f3 == 3'd5 && w[30]);
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
      end
      7'h03: begin
        c.regfile_wr_en = 1; c.mem_read = 1; c.mem_to_reg = 1; c.rs2_select = 1;
        c.alu_select = 3'd1; c.alu_operation = 8'h01; c.mem_funct3 = f3;
        c.imm = 32'(sw >>> 20);
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      end
      7'h23: begin
        c.mem_write = 1; c.rs2_select = 1; c.alu_select = 3'd1;
        c.alu_operation = 8'h01; c.mem_funct3 = f3;
        c.imm = (32'(sw >>> 25) << 5) | 32'(w[11:7]);
        ok = (f3 <= 3'd2);
      end
      7'h63: begin
        c.branch = 1; c.alu_select = 3'd2; c.alu_operation = 8'(f3);
        c.imm = (32'(sw >>> 31) << 12) | (32'(w[7]) << 11) |
                (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        ok = (f3 != 3'd2 && f3 != 3'd3);
      end
      7'h6F: begin
        c.regfile_wr_en = 1; c.jump = 1; c.rs1_select = 1; c.rs2_select = 1;
        c.alu_select = 3'd1; c.alu_operation = 8'h01;
        c.imm = (32'(sw >>> 31) << 20) | (32'(w[19:12]) << 12) |
                (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      7'h67: begin
        c.regfile_wr_en = 1; c.jump = 1; c.rs2_select = 1;
        c.alu_select = 3'd1; c.alu_operation = 8'h01;
        c.imm = 32'(sw >>> 20);
        ok = (f3 == 3'd0);
      end
      7'h37: begin
        c.regfile_wr_en = 1; c.rs1 = 5'd0; c.rs2_select = 1;
        c.alu_select = 3'd1; c.alu_operation = 8'h01; c.imm = w & 32'hFFFFF000;
      end
      7'h17: begin
        c.regfile_wr_en = 1; c.rs1_select = 1; c.rs2_select = 1;
        c.alu_select = 3'd1; c.alu_operation = 8'h01; c.imm = w & 32'hFFFFF000;
      end
      7'h0F: ;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      c = '0;
      c.illegal = 1'b1;
      c.pc = a;
    end
    if (w[11:7] == 5'd0) c.regfile_wr_en = 1'b0;
    return c;
  endfunction

  // For illegal entries only the enables, ALU fields, pc and flag are defined.
  function automatic ctrl_t visible(input ctrl_t c);
    ctrl_t v;
    v = c;
    if (c.illegal) begin
      v = '0;
      v.illegal = 1'b1; v.pc = c.pc;
      v.regfile_wr_en = c.regfile_wr_en; v.mem_read = c.mem_read;
      v.mem_write = c.mem_write; v.mem_to_reg = c.mem_to_reg;
      v.branch = c.branch; v.jump = c.jump;
      v.alu_select = c.alu_select; v.alu_operation = c.alu_operation;
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                             7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instruction = '0; pc = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({out_valid, in_ready, illegal_count} !== {1'b0, 1'b1, 16'd0})
      begin bad++; $display("FAIL reset_flags got ov=%b ir=%b ic=%0d want ov=0 ir=1 ic=0",
                            out_valid, in_ready, illegal_count); end
    total++;
    if (ctrl !== ctrl_t'('0))
      begin bad++; $display("FAIL reset_ctrl got %h want 0", ctrl); end
  endtask

  task automatic test_alu_op();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h002081B3; pc = 32'h100;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, ctrl.alu_operation, ctrl.rd, ctrl.rs1, ctrl.rs2, ctrl.regfile_wr_en,
         ctrl.rs2_select, ctrl.illegal, ctrl.pc} !==
        {1'b1, 8'h01, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 32'h100})
      begin bad++; $display("FAIL add_decode got ov=%b op=%h rd=%0d rs1=%0d rs2=%0d we=%b s2=%b ill=%b want 1 01 3 1 2 1 0 0",
                            out_valid, ctrl.alu_operation, ctrl.rd, ctrl.rs1, ctrl.rs2,
                            ctrl.regfile_wr_en, ctrl.rs2_select, ctrl.illegal); end
  endtask

  task automatic test_load_branch();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h00812283; pc = 32'h200;
    tick();
    instruction = 32'h00208463; pc = 32'h204;
    total++;
    if ({out_valid, ctrl.mem_read, ctrl.mem_to_reg, ctrl.imm, ctrl.mem_funct3, ctrl.rd} !==
        {1'b1, 1'b1, 1'b1, 32'd8, 3'd2, 5'd5})
      begin bad++; $display("FAIL lw_decode got ov=%b mr=%b m2r=%b imm=%h f3=%0d rd=%0d want 1 1 1 8 2 5",
                            out_valid, ctrl.mem_read, ctrl.mem_to_reg, ctrl.imm,
                            ctrl.mem_funct3, ctrl.rd); end
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, ctrl.branch, ctrl.regfile_wr_en, ctrl.imm, ctrl.alu_select} !==
        {1'b1, 1'b1, 1'b0, 32'd8, 3'd2})
      begin bad++; $display("FAIL beq_decode got ov=%b br=%b we=%b imm=%h sel=%0d want 1 1 0 8 2",
                            out_valid, ctrl.branch, ctrl.regfile_wr_en, ctrl.imm, ctrl.alu_select); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; instruction = 32'h0; pc = 32'h300;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({out_valid, ctrl.illegal, ctrl.regfile_wr_en, ctrl.mem_read, ctrl.mem_write,
           ctrl.mem_to_reg, ctrl.branch, ctrl.jump, ctrl.alu_select, ctrl.alu_operation} !==
          {1'b1, 1'b1, 6'b0, 3'd0, 8'h00})
        begin bad++; $display("FAIL illegal_entry%0d got ov=%b ill=%b en=%b%b%b%b%b%b sel=%0d op=%h want ov=1 ill=1 en=0 sel=0 op=0",
                              i, out_valid, ctrl.illegal, ctrl.regfile_wr_en, ctrl.mem_read,
                              ctrl.mem_write, ctrl.mem_to_reg, ctrl.branch, ctrl.jump,
                              ctrl.alu_select, ctrl.alu_operation); end
    end
    instruction = 32'hFFF00093;
    tick();
    in_valid = 1'b0;
    total++;
    if ({ctrl.imm, ctrl.rs2_select, ctrl.illegal, illegal_count} !== {32'hFFFFFFFF, 1'b1, 1'b0, 16'd2})
      begin bad++; $display("FAIL addi_after_illegal got imm=%h s2=%b ill=%b ic=%0d want ffffffff 1 0 2",
                            ctrl.imm, ctrl.rs2_select, ctrl.illegal, illegal_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; instruction = 32'h002081B3; pc = 32'h400;
    tick();
    instruction = 32'h00812283; pc = 32'h404;
    tick();
    instruction = 32'hFFF00093; pc = 32'h408;
    total++;
    if ({in_ready, out_valid, ctrl.rd} !== {1'b0, 1'b1, 5'd3})
      begin bad++; $display("FAIL full_after_two got ir=%b ov=%b rd=%0d want 0 1 3", in_ready, out_valid, ctrl.rd); end
    tick();
    tick();
    total++;
    if ({in_ready, out_valid, ctrl.rd, ctrl.pc} !== {1'b0, 1'b1, 5'd3, 32'h400})
      begin bad++; $display("FAIL head_stable got ir=%b ov=%b rd=%0d pc=%h want 0 1 3 400",
                            in_ready, out_valid, ctrl.rd, ctrl.pc); end
    out_ready = 1'b1;
    tick();
    total++;
    if ({in_ready, out_valid, ctrl.rd} !== {1'b1, 1'b1, 5'd5})
      begin bad++; $display("FAIL second_entry got ir=%b ov=%b rd=%0d want 1 1 5", in_ready, out_valid, ctrl.rd); end
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, ctrl.rd, ctrl.pc} !== {1'b1, 5'd1, 32'h408})
      begin bad++; $display("FAIL third_entry got ov=%b rd=%0d pc=%h want 1 1 408", out_valid, ctrl.rd, ctrl.pc); end
    tick();
    total++;
    if (out_valid !== 1'b0)
      begin bad++; $display("FAIL drained got ov=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; instruction = 32'h002081B3; pc = 32'h500;
    tick();
    tick();
    instruction = 32'h0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, in_ready, illegal_count} !== {1'b0, 1'b1, 16'd0})
      begin bad++; $display("FAIL flush_clears got ov=%b ir=%b ic=%0d want 0 1 0", out_valid, in_ready, illegal_count); end
    tick();
    total++;
    if (out_valid !== 1'b0)
      begin bad++; $display("FAIL flush_drops_offer got ov=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; instruction = 32'h0; pc = 32'h600;
    tick();
    tick();
    total++;
    if ({in_ready, illegal_count} !== {1'b0, 16'd2})
      begin bad++; $display("FAIL prefill got ir=%b ic=%0d want 0 2", in_ready, illegal_count); end
    rst = 1'b1; out_ready = 1'b1; instruction = 32'hFFF00093;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, in_ready, illegal_count} !== {1'b0, 1'b1, 16'd0})
      begin bad++; $display("FAIL reset_mid got ov=%b ir=%b ic=%0d want 0 1 0", out_valid, in_ready, illegal_count); end
    tick();
    total++;
    if (out_valid !== 1'b0)
      begin bad++; $display("FAIL reset_drops_offer got ov=%b want 0", out_valid); end
  endtask

  task automatic test_random();
    ctrl_t q[$];
    ctrl_t e;
    logic [15:0] ill;
    logic do_push, do_pop;
    do_reset();
    ill = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      total++;
      if (out_valid !== (q.size() != 0))
        begin bad++; $display("FAIL rnd_out_valid cyc=%0d got %b want %b", cyc, out_valid, q.size() != 0); end
      total++;
      if (in_ready !== (q.size() < DEPTH))
        begin bad++; $display("FAIL rnd_in_ready cyc=%0d got %b want %b", cyc, in_ready, q.size() < DEPTH); end
      total++;
      if (illegal_count !== ill)
        begin bad++; $display("FAIL rnd_illegal_count cyc=%0d got %0d want %0d", cyc, illegal_count, ill); end
      if (q.size() != 0) begin
        total++;
        if (visible(ctrl) !== visible(q[0]))
          begin bad++; $display("FAIL rnd_ctrl cyc=%0d got %h want %h", cyc, visible(ctrl), visible(q[0])); end
      end
      in_valid    = ($urandom_range(0, 3) != 0);
      instruction = rand_instr();
      pc          = $urandom() & 32'hFFFFFFFC;
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      do_push = in_valid && (q.size() < DEPTH) && !flush;
      do_pop  = (q.size() != 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          e = ref_decode(instruction, pc);
          q.push_back(e);
          if (e.illegal && ill != 16'hFFFF) ill = ill + 16'd1;
        end
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instruction = '0; pc = '0;
    test_reset();
    test_alu_op();
    test_load_branch();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
